// File: rtl/wb_lsu_master_if.sv
// WISHBONE_IF: single-initiator bus bundle between the load/store unit and the
// ROM/RAM/peripheral slaves.
//   cyc, stb      bus cycle / strobe (initiator)
//   we            1 = write (initiator)
//   addr[31:0]    byte address (initiator)
//   width[1:0]    00 byte, 01 half, 1x word (initiator)
//   data_write    right-aligned store data (initiator)
//   ack           transfer done (slave)
//   data_read     right-aligned load data (slave)
interface WISHBONE_IF;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  width;
  logic [31:0] data_write;
  logic        ack;
  logic [31:0] data_read;

  modport master (
    output cyc, stb, we, addr, width, data_write,
    input  ack, data_read
  );

  modport slave (
    input  cyc, stb, we, addr, width, data_write,
    output ack, data_read
  );
endinterface

// File: rtl/wb_lsu_master.sv
// wb_lsu_master: turns one load/store request from the memory stage into a
// single Wishbone bus cycle and returns an extended load result (or an error
// on timeout / rejected misalignment). One transaction outstanding at a time.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_addr          byte address
//   req_width         00 byte, 01 half, 1x word
//   req_signed        loads: sign- (1) or zero- (0) extend
//   req_wdata         right-aligned store data
//   rsp_valid         one-cycle completion pulse
//   rsp_data          extended load data; 0 for stores and errors
//   rsp_err           timeout or misalignment, qualified by rsp_valid
//   mem_wb            Wishbone initiator port
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response cycle (rsp_valid pulse), then back to IDLE
module wb_lsu_master #(
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          CHECK_ALIGN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  WISHBONE_IF.master  mem_wb
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        bus_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  width_q;
  logic [31:0] wdata_q;
  logic        signed_q;
  logic        rej_pend;
  logic [15:0] tmo_cnt;
  logic        misaligned;

  always_comb begin
    misaligned = CHECK_ALIGN &&
                 (((req_width == 2'b01) && req_addr[0]) ||
                  (req_width[1] && (req_addr[1:0] != 2'b00)));
  end

  function automatic logic [31:0] extend(input logic [31:0] d,
                                         input logic [1:0]  w,
                                         input logic        s);
    case (w)
      2'b00:   extend = {{24{s & d[7]}}, d[7:0]};
      2'b01:   extend = {{16{s & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign req_ready         = (state == IDLE);
  assign mem_wb.cyc        = bus_q;
  assign mem_wb.stb        = bus_q;
  assign mem_wb.we         = we_q;
  assign mem_wb.addr       = addr_q;
  assign mem_wb.width      = width_q;
  assign mem_wb.data_write = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      width_q   <= '0;
      wdata_q   <= '0;
      signed_q  <= 1'b0;
      rej_pend  <= 1'b0;
      tmo_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            addr_q   <= req_addr;
            width_q  <= req_width;
            wdata_q  <= req_wdata;
            signed_q <= req_signed;
            tmo_cnt  <= '0;
            if (misaligned) begin
              // Rejected requests spend one silent cycle in RESP so the error
              // arrives with the same latency as a zero-wait bus access.
              state    <= RESP;
              rej_pend <= 1'b1;
            end else begin
              state <= BUS;
              bus_q <= 1'b1;
            end
          end
        end
        BUS: begin
          if (mem_wb.ack) begin
            state     <= RESP;
            bus_q     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= we_q ? 32'd0 : extend(mem_wb.data_read, width_q, signed_q);
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= RESP;
            bus_q     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP: begin
          if (rej_pend) begin
            rej_pend  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
module tb_wb_lsu_master;
  localparam int TMO = 8;
  localparam bit ALIGN = 1'b1;

  logic        clk;
  logic        rst;
  logic        req_valid, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data;

  logic        req2_valid, req2_we, req2_signed;
  logic [31:0] req2_addr, req2_wdata;
  logic [1:0]  req2_width;
  logic        req2_ready, rsp2_valid, rsp2_err;
  logic [31:0] rsp2_data;

  WISHBONE_IF bus();
  WISHBONE_IF bus2();

  wb_lsu_master #(.TIMEOUT(TMO), .CHECK_ALIGN(ALIGN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_width(req_width), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_wb(bus)
  );

  wb_lsu_master #(.TIMEOUT(TMO), .CHECK_ALIGN(1'b0)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req2_valid), .req_ready(req2_ready), .req_we(req2_we),
    .req_addr(req2_addr), .req_width(req2_width), .req_signed(req2_signed),
    .req_wdata(req2_wdata),
    .rsp_valid(rsp2_valid), .rsp_data(rsp2_data), .rsp_err(rsp2_err),
    .mem_wb(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave models ----------------
  logic [7:0] mem [256];
  int         ack_wait;
  bit         never_ack;
  bit         ack_force;
  int         bus_cycles;
  logic [7:0] sa;

  always @(posedge clk) bus_cycles <= (bus.cyc && bus.stb) ? bus_cycles + 1 : 0;

  always_comb begin
    sa = bus.addr[7:0];
    bus.data_read = {mem[sa + 8'd3], mem[sa + 8'd2], mem[sa + 8'd1], mem[sa]};
    bus.ack = (bus.cyc && bus.stb && !never_ack && (bus_cycles == ack_wait)) || ack_force;
  end

  assign bus2.ack       = bus2.cyc & bus2.stb;
  assign bus2.data_read = 32'hCAFE0041;

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic logic [31:0] word_at(input logic [31:0] a);
    int b;
    longint r;
    b = int'(a % 256);
    r = longint'(mem[b]) + 256 * longint'(mem[(b + 1) % 256]) +
        65536 * longint'(mem[(b + 2) % 256]) + 16777216 * longint'(mem[(b + 3) % 256]);
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] width, input logic sgn);
    longint v;
    if (width == 2'b00) begin
      v = longint'(w % 256);
      if (sgn && v >= 128) v = v - 256;
    end else if (width == 2'b01) begin
      v = longint'(w % 65536);
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  bit          chk_en = 0;
  bit          act = 0;
  int          t = 0;
  int          m_len, m_resp, n_acc = 0;
  logic        m_err, m_we;
  logic [31:0] m_data, m_addr, m_wd;
  logic [1:0]  m_width;
  bit          exp_cyc, exp_rv, misal;
  int          obs_len, obs_lat;
  logic [31:0] obs_data;
  logic        obs_err;

  initial begin : model_cmp
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0;
      end else if (act) begin
        t++;
        if (t > m_resp) act = 0;
      end else if (req_valid) begin
        act = 1; t = 1; n_acc++;
        m_addr = req_addr; m_we = req_we; m_width = req_width; m_wd = req_wdata;
        misal = (req_width == 2'b01 && req_addr % 2 != 0) ||
                (req_width >= 2'b10 && req_addr % 4 != 0);
        if (ALIGN && misal) begin
          m_len = 0; m_resp = 2; m_err = 1; m_data = 0;
        end else begin
          if (never_ack || ack_wait >= TMO) begin
            m_len = TMO; m_err = 1; m_data = 0;
          end else begin
            m_len = ack_wait + 1; m_err = 0;
            m_data = req_we ? 32'd0 : m_ext(word_at(req_addr), req_width, req_signed);
          end
          m_resp = m_len + 1;
        end
        obs_len = 0; obs_lat = 0; obs_data = 'x; obs_err = 'x;
      end
      exp_cyc = act && (t <= m_len);
      exp_rv  = act && (t == m_resp);
      if (bus.cyc === 1'b1) obs_len++;
      if (rsp_valid === 1'b1) begin
        obs_lat = t; obs_data = rsp_data; obs_err = rsp_err;
      end
      if (chk_en) begin
        chk1("req_ready", req_ready, !act);
        chk1("cyc", bus.cyc, exp_cyc);
        chk1("stb", bus.stb, exp_cyc);
        chk1("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
          chk32("rsp_data", rsp_data, m_data);
          chk1("rsp_err", rsp_err, m_err);
        end
        if (exp_cyc) begin
          chk32("bus_addr", bus.addr, m_addr);
          chk1("bus_we", bus.we, m_we);
          chk32("bus_width", {30'd0, bus.width}, {30'd0, m_width});
          chk32("bus_wdata", bus.data_write, m_wd);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] w,
                       input logic s, input logic [31:0] wd);
    int n0;
    bit ok;
    @(negedge clk); #1;
    req_we = we; req_addr = a; req_width = w; req_signed = s; req_wdata = wd;
    req_valid = 1'b1;
    n0 = n_acc; ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk); #1;
      if (n_acc != n0) ok = 1;
    end
    req_valid = 1'b0;
    chk1("accept_bound", ok, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); #1;
      if (!act) ok = 1;
    end
    chk1("idle_bound", ok, 1'b1);
  endtask

  task automatic expect_done(input string nm, input logic [31:0] d, input logic e,
                             input int len, input int lat);
    chk32({nm, "_data"}, obs_data, d);
    chk1({nm, "_err"}, obs_err, e);
    chk32({nm, "_buslen"}, obs_len, len);
    chk32({nm, "_lat"}, obs_lat, lat);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int n0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h10] = 8'h80;
    mem[8'h20] = 8'hEF; mem[8'h21] = 8'hBE; mem[8'h22] = 8'hAD; mem[8'h23] = 8'hDE;
    ack_wait = 0; never_ack = 0; ack_force = 0;
    req_valid = 0; req_we = 0; req_addr = 0; req_width = 0; req_signed = 0; req_wdata = 0;
    req2_valid = 0; req2_we = 0; req2_addr = 0; req2_width = 0; req2_signed = 0; req2_wdata = 0;
    rst = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk1("rst_cyc", bus.cyc, 1'b0);
    chk1("rst_we", bus.we, 1'b0);
    chk32("rst_addr", bus.addr, 32'd0);
    chk32("rst_width", {30'd0, bus.width}, 32'd0);
    chk32("rst_wdata", bus.data_write, 32'd0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk32("rst_rsp_data", rsp_data, 32'd0);
    chk1("rst_ready", req_ready, 1'b1);
    rst = 1'b0;
    chk_en = 1;

    // loads with zero-wait ack
    issue(0, 32'h10, 2'b00, 1, 0); wait_idle();
    expect_done("ld_b_s", 32'hFFFFFF80, 0, 1, 2);
    issue(0, 32'h10, 2'b00, 0, 0); wait_idle();
    expect_done("ld_b_u", 32'h00000080, 0, 1, 2);
    issue(0, 32'h20, 2'b01, 1, 0); wait_idle();
    expect_done("ld_h_s", 32'hFFFFBEEF, 0, 1, 2);
    issue(0, 32'h20, 2'b01, 0, 0); wait_idle();
    expect_done("ld_h_u", 32'h0000BEEF, 0, 1, 2);
    issue(0, 32'h20, 2'b10, 1, 0); wait_idle();
    expect_done("ld_w", 32'hDEADBEEF, 0, 1, 2);
    issue(0, 32'h22, 2'b01, 1, 0); wait_idle();
    expect_done("ld_h_hi", 32'hFFFFDEAD, 0, 1, 2);

    // store with three wait states
    ack_wait = 3;
    issue(1, 32'h40, 2'b10, 0, 32'h12345678); wait_idle();
    expect_done("st_w", 32'd0, 0, 4, 5);

    // timeout, then a normal request
    never_ack = 1;
    issue(0, 32'h20, 2'b10, 0, 0); wait_idle();
    expect_done("tmo", 32'd0, 1, 8, 9);
    never_ack = 0; ack_wait = 0;
    issue(0, 32'h10, 2'b00, 0, 0); wait_idle();
    expect_done("post_tmo", 32'h00000080, 0, 1, 2);

    // ack on the last allowed cycle, and one cycle too late
    ack_wait = 7;
    issue(0, 32'h20, 2'b10, 0, 0); wait_idle();
    expect_done("ack_last", 32'hDEADBEEF, 0, 8, 9);
    ack_wait = 8;
    issue(0, 32'h20, 2'b10, 0, 0); wait_idle();
    expect_done("ack_late", 32'd0, 1, 8, 9);
    ack_wait = 0;

    // misalignment rejected without a bus cycle
    issue(0, 32'h41, 2'b10, 0, 0); wait_idle();
    expect_done("mis_w", 32'd0, 1, 0, 2);
    issue(0, 32'h21, 2'b01, 1, 0); wait_idle();
    expect_done("mis_h", 32'd0, 1, 0, 2);

    // same misaligned request passes through when checking is off
    @(negedge clk); #1;
    req2_we = 0; req2_addr = 32'h41; req2_width = 2'b10; req2_signed = 0; req2_valid = 1;
    @(negedge clk); #1;
    req2_valid = 0;
    chk1("pass_cyc", bus2.cyc, 1'b1);
    chk32("pass_addr", bus2.addr, 32'h41);
    @(negedge clk); #1;
    chk1("pass_rsp_valid", rsp2_valid, 1'b1);
    chk1("pass_rsp_err", rsp2_err, 1'b0);
    chk32("pass_rsp_data", rsp2_data, 32'hCAFE0041);
    @(negedge clk); #1;
    chk1("pass_rsp_pulse", rsp2_valid, 1'b0);

    // ack outside a bus cycle must not produce a response
    ack_force = 1;
    repeat (4) @(negedge clk);
    #1;
    ack_force = 0;

    // req_valid held: accepted only when idle, every third cycle
    @(negedge clk); #1;
    req_we = 0; req_addr = 32'h10; req_width = 2'b00; req_signed = 1; req_valid = 1;
    n0 = n_acc;
    for (int i = 0; i < 20 && n_acc < n0 + 2; i++) begin
      @(negedge clk); #1;
    end
    req_valid = 0;
    chk32("b2b_count", n_acc, n0 + 2);
    wait_idle();
    expect_done("b2b", 32'hFFFFFF80, 0, 1, 2);

    // reset in the middle of a bus cycle
    never_ack = 1;
    issue(0, 32'h20, 2'b10, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk1("pre_rst_stb", bus.stb, 1'b1);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk1("mid_rst_cyc", bus.cyc, 1'b0);
    chk1("mid_rst_stb", bus.stb, 1'b0);
    chk1("mid_rst_rsp", rsp_valid, 1'b0);
    chk1("mid_rst_ready", req_ready, 1'b1);
    repeat (10) @(negedge clk);
    #1;
    never_ack = 0;
    issue(0, 32'h20, 2'b10, 0, 0); wait_idle();
    expect_done("post_rst", 32'hDEADBEEF, 0, 1, 2);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
- Wishbone initiator that turns single load/store requests from the core pipeline into WISHBONE_IF bus cycles.
- Drives cyc/stb/we/addr/width/data_write, waits for slave ack, then returns the result.
- Load data is sign- or zero-extended; a cycle with no ack is terminated by a timeout.
- Sits between the memory stage and the ROM/RAM/peripheral slaves; one transaction outstanding at a time.

Parameters:
- TIMEOUT, 255, cycles in BUS state without ack before abort (1..65535).
- CHECK_ALIGN, 0, 1 = misaligned half/word requests are rejected with error and no bus cycle; 0 = passed to the bus unchanged.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_width  in  2  00 byte, 01 half, 1x word (same encoding as bus width).
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse: transaction complete.
- rsp_data  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid: timeout or misalignment.
- mem_wb  WISHBONE_IF.master  —  bus port:
  - drives cyc, stb, we, addr[31:0], width[1:0], data_write[31:0];
  - samples ack, data_read[31:0].

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - state=IDLE; cyc=stb=we=0; addr=width=data_write=0.
  - rsp_valid=rsp_err=0; rsp_data=0; timeout counter=0.
  - Applies mid-transaction: the bus cycle is dropped with no response.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we/addr/width/signed/wdata.
  - If CHECK_ALIGN=1 and (half with addr[0]=1, or word with addr[1:0]≠0): go to RESP with err=1.
  - Otherwise go to BUS.
- BUS:
  - cyc=stb=1; we/addr/width/data_write held stable from latched values.
  - Ack is sampled every cycle, including the first BUS cycle; combinational same-cycle ack is supported.
  - On ack: capture data_read, go to RESP, err=0.
  - No ack: counter increments. At counter==TIMEOUT-1 without ack: go to RESP with err=1.
- RESP:
  - rsp_valid=1 for exactly one cycle; cyc=stb=0; return to IDLE.
  - req_ready=0 here, so back-to-back requests are accepted every 3 cycles minimum.
- Latency with same-cycle ack:
  - request accepted at edge N; cyc/stb high in cycle N+1; rsp_valid in cycle N+2.
- Load extension, from captured data_read:
  - byte: bits[7:0], bit 7 replicated when signed.
  - half: bits[15:0], bit 15 replicated when signed.
  - word: unchanged; req_signed ignored.
- Store or error: rsp_data=0.
- Store data: data_write=wdata, unmasked. Slave honours width.
- Outputs are registered; no combinational path from req_* to mem_wb.
- Counter is cleared on entry to BUS.
- Ack seen outside BUS is ignored.
- req_valid in BUS/RESP is ignored. The requester must hold it until req_ready.

Test Plan:
- Byte loads from ROM: ROM[0x10]=0x80, req_width=00.
  - signed → rsp_data=0xFFFFFF80, rsp_err=0, rsp_valid exactly 2 cycles after acceptance.
  - unsigned → 0x00000080.
- Signed half and word loads: ROM[0x20..0x23]=EF BE AD DE.
  - signed half @0x20 → 0xFFFFBEEF.
  - word @0x20 → 0xDEADBEEF.
- Store: req_we=1, addr=0x40, width=10, wdata=0x12345678, ack held low 3 cycles.
  - cyc/stb/we high 4 cycles; addr/data stable throughout; then rsp_valid=1, rsp_data=0, rsp_err=0.
- Timeout: TIMEOUT=8, slave never acks.
  - cyc/stb high exactly 8 cycles; rsp_valid with rsp_err=1, rsp_data=0; next request accepted normally.
- Misaligned: CHECK_ALIGN=1, word load @0x41.
  - cyc never asserted; rsp_err=1 two cycles after acceptance.
  - Same request with CHECK_ALIGN=0 → bus cycle issued with addr=0x41.
- Reset mid-BUS: rst=1 for one cycle while stb=1.
  - Next cycle cyc=stb=0, rsp_valid stays 0, req_ready=1.
